// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction source for the execute stage. Holds the fetch PC, a
// word-addressed instruction memory with a write (load) port, and one
// registered instr/instr_pc pair qualified by instr_valid. Branch and jump
// redirects resolved by execute are taken back here; each redirect discards
// the wrong-path word and inserts exactly one bubble.
//
// Optional feature macro: HALT_DETECT_EN
//   defined   -> a fetched 32'hFC000000 is presented and fetch then parks in
//                HALT (halted=1) until a redirect or reset.
//   undefined -> halted is tied low and 32'hFC000000 is an ordinary word.
//
// Parameters
//   IMEM_AW       word-address width, memory depth = 2**IMEM_AW words
//   RESET_PC      fetch PC after reset (bits [1:0] ignored)
//
// Ports
//   CLK           in   clock, rising edge
//   RST_N         in   asynchronous reset, active low
//   stall         in   hold all fetch state this cycle
//   branch_taken  in   presented instr resolved as a taken branch
//   branch_off    in   signed word offset of that branch
//   jump          in   presented instr is a jump (wins over branch_taken)
//   jump_target   in   jump target word index
//   load_en       in   instruction memory write enable
//   load_addr     in   instruction memory write word address
//   load_data     in   instruction memory write data
//   instr         out  instruction to execute
//   instr_pc      out  byte address of instr
//   instr_valid   out  instr/instr_pc hold a real instruction
//   halted        out  fetch stopped on the halt word
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [15:0]        branch_off,
    input  logic               jump,
    input  logic [25:0]        jump_target,
    input  logic               load_en,
    input  logic [IMEM_AW-1:0] load_addr,
    input  logic [31:0]        load_data,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

`ifdef HALT_DETECT_EN
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;
`endif

    state_t r_state;
    state_t w_state_next;

    logic [31:0] r_imem [2**IMEM_AW];

    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;

    logic [IMEM_AW-1:0] w_rd_idx;
    logic [31:0]        w_rdata;
    logic               w_redirect_req;
    logic [31:0]        w_seq_pc;
    logic [31:0]        w_branch_disp;
    logic [31:0]        w_target;
    logic               w_do_fetch;

    // ------------------------------------------------------------------
    // Instruction memory. The read is a plain array lookup that is captured
    // into r_instr below, which gives the one-cycle read latency; because
    // that capture and this write share the same edge, a colliding load
    // returns the old word.
    // ------------------------------------------------------------------
    // NOTE: the memory array has no reset; contents survive RST_N so code
    // can be loaded while the fetch unit is held in reset.
    always_ff @(posedge CLK) begin
        if (load_en) begin
            r_imem[load_addr] <= load_data;
        end
    end

    assign w_rd_idx = r_fetch_pc[IMEM_AW+1:2];
    assign w_rdata  = r_imem[w_rd_idx];

    // ------------------------------------------------------------------
    // Redirect target. Only a presented (valid) instruction can redirect.
    // ------------------------------------------------------------------
    assign w_redirect_req = r_instr_valid & (jump | branch_taken);
    assign w_seq_pc       = r_instr_pc + 32'd4;
    assign w_branch_disp  = {{14{branch_off[15]}}, branch_off, 2'b00};
    assign w_target       = jump ? {w_seq_pc[31:28], jump_target, 2'b00}
                                 : (w_seq_pc + w_branch_disp);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. Redirect beats stall; stall holds state.
    // ------------------------------------------------------------------
    // NOTE: combinational blocks assign a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (w_redirect_req) begin
            w_state_next = BUBBLE;
        end else if (!stall) begin
            w_state_next = RUN;
`ifdef HALT_DETECT_EN
            // Stay parked, or park on the edge that presents the halt word.
            if (r_state == HALT || w_rdata == HALT_WORD) begin
                w_state_next = HALT;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_do_fetch = !w_redirect_req && !stall;
        halted     = 1'b0;
`ifdef HALT_DETECT_EN
        if (r_state == HALT) begin
            w_do_fetch = 1'b0;
            halted     = 1'b1;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Fetch datapath. On a redirect instr/instr_pc keep their old contents;
    // only instr_valid drops, which is what marks the bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_fetch_pc    <= RESET_PC_ALIGNED;
            r_instr       <= 32'h0;
            r_instr_pc    <= RESET_PC_ALIGNED;
            r_instr_valid <= 1'b0;
        end else if (w_redirect_req) begin
            r_fetch_pc    <= w_target;
            r_instr_valid <= 1'b0;
        end else if (w_do_fetch) begin
            r_instr       <= w_rdata;
            r_instr_pc    <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_fetch_pc    <= r_fetch_pc + 32'd4;
        end
    end

    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit. The stimulus process drives one cycle
// at a time and, right after each rising edge, pushes the hand-computed
// expected outputs for that edge into a queue. A monitor pops one entry per
// falling edge and compares. instr is taken from a bench-side copy of the
// words the bench loaded, updated after each edge (old word on collision).
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        CLK;
    logic        RST_N;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_target;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        halted;

    instr_fetch_unit #(
        .IMEM_AW  (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .jump         (jump),
        .jump_target  (jump_target),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .halted       (halted)
    );

    typedef struct {
        logic        v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        h;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_model [256];
    int          total = 0;
    int          bad   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr_valid", {31'h0, instr_valid}, {31'h0, e.v});
                check("halted", {31'h0, halted}, {31'h0, e.h});
                if (e.v) begin
                    check("instr", instr, e.instr);
                    check("instr_pc", instr_pc, e.pc);
                end
            end
        end
    end

    // One clock of stimulus; expected state after the edge goes on the queue.
    task automatic step(input logic s, input logic b, input logic [15:0] off,
                        input logic j, input logic [25:0] t,
                        input logic ev, input logic [31:0] epc, input logic eh);
        exp_t e;
        stall        = s;
        branch_taken = b;
        branch_off   = off;
        jump         = j;
        jump_target  = t;
        @(posedge CLK);
        e.v     = ev;
        e.pc    = epc;
        e.instr = mem_model[epc[9:2]];
        e.h     = eh;
        sb.push_back(e);
        if (load_en) mem_model[load_addr] = load_data;
        #1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_off   = 16'h0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        load_en      = 1'b0;
    endtask

    task automatic run(input logic [31:0] epc);
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, epc, 1'b0);
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(posedge CLK);
        mem_model[a] = d;
        #1;
        load_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {31'h0, instr_valid}, 32'h0);
        check({tag, "_instr"}, instr, 32'h0);
        check({tag, "_pc"}, instr_pc, 32'h0);
        check({tag, "_halted"}, {31'h0, halted}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        RST_N        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        branch_off   = 16'h0;
        jump         = 1'b0;
        jump_target  = 26'h0;
        load_en      = 1'b0;
        load_addr    = 8'h0;
        load_data    = 32'h0;
        for (int i = 0; i < 256; i++) mem_model[i] = 32'hx;

        // Test 1: load code under reset, release, in-order fetch.
        for (int i = 0; i < 32; i++) load_word(i[7:0], 32'hA000_0000 | (i * 32'h0001_0001));
        check_reset_values("rst1");
        RST_N = 1'b1;
        run(32'h0);
        run(32'h4);
        run(32'h8);
        run(32'hC);

        // Jump back to 0x8 from 0xC, then branch -2 words from 0x8 -> 0x4.
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h2, 1'b0, 32'h0, 1'b0);
        run(32'h8);
        step(1'b0, 1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        run(32'h4);

        // Test 3: jump to word 0x10 from 0x4, then jump+branch -> jump wins.
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h10, 1'b0, 32'h0, 1'b0);
        run(32'h40);
        run(32'h44);
        step(1'b0, 1'b1, 16'h0010, 1'b1, 26'h2, 1'b0, 32'h0, 1'b0);
        run(32'h8);

        // Test 4: stall 3 cycles at 0x8, then stall+jump at 0xC.
        repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h8, 1'b0);
        run(32'hC);
        step(1'b1, 1'b0, 16'h0, 1'b1, 26'h1, 1'b0, 32'h0, 1'b0);
        run(32'h4);

        // Redirect during a bubble is ignored; stall during a bubble holds it.
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 16'h0100, 1'b0, 26'h0, 1'b1, 32'h0, 1'b0);
        run(32'h4);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h4, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 1'b0);
        run(32'h10);

        // Test 5: asynchronous reset pulse in the low clock phase.
        @(negedge CLK);
        #1 RST_N = 1'b0;
        #1 check_reset_values("rst_async");
        #1 RST_N = 1'b1;
        run(32'h0);
        run(32'h4);
        // Load into the word being read on this same edge: old word expected.
        load_en   = 1'b1;
        load_addr = 8'd2;
        load_data = 32'h5555_AAAA;
        run(32'h8);
        run(32'hC);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h2, 1'b0, 32'h0, 1'b0);
        run(32'h8);
        run(32'hC);

        // Test 6: halt word at imem[3].
        @(negedge CLK);
        #1 RST_N = 1'b0;
        load_word(8'd3, HALT_WORD);
        RST_N = 1'b1;
        run(32'h0);
        run(32'h4);
        run(32'h8);
`ifdef HALT_DETECT_EN
        step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hC, 1'b1);
        repeat (10) step(1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hC, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1, 26'h0, 1'b0, 32'h0, 1'b0);
        run(32'h0);
`else
        run(32'hC);
        run(32'h10);
        run(32'h14);
`endif

        repeat (2) @(posedge CLK);
        #1 check("sb_drain", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
